// File: rtl/ptc_wb_master.sv
// WISHBONE classic master issuing one read/write at a time to the PTC slave, with timeout.
// Latency: bus cycle starts at the accept edge; response registered at the terminating edge.
// Backpressure: cmd_ready_o only in IDLE; response held until rsp_ready_i, no command buffering.
module ptc_wb_master #(
    parameter int DW         = 32,
    parameter int TMO_CYCLES = 64,
    parameter int TMO_W      = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [31:0]   cmd_adr_i,
    input  logic [DW-1:0] cmd_dat_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_dat_o,
    output logic          rsp_err_o,
    output logic          rsp_tmo_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [31:0]   wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit               TMO_EN   = (TMO_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    state_t           state_q, state_nxt;
    logic             cyc_q, cyc_d;
    logic [3:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]    rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_tmo_q, rsp_tmo_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tmo_hit;

    // Word-aligned bus: the byte offset of the command address is dropped.
    logic adr_lsb_unused;
    assign adr_lsb_unused = ^cmd_adr_i[1:0];

    assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

    always_comb begin
        state_nxt   = state_q;
        cyc_d       = cyc_q;
        sel_d       = sel_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d      = cmd_we_i;
                    adr_d     = {cmd_adr_i[31:2], 2'b00};
                    dat_d     = cmd_dat_i;
                    cyc_d     = 1'b1;
                    sel_d     = 4'hF;
                    cnt_d     = '0;
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                // Error outranks ack, and a real termination outranks the timeout.
                if (wb_err_i || wb_ack_i || tmo_hit) begin
                    cyc_d       = 1'b0;
                    sel_d       = 4'h0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = wb_err_i || !wb_ack_i;
                    rsp_tmo_d   = !wb_err_i && !wb_ack_i;
                    rsp_dat_d   = (!wb_err_i && wb_ack_i && !we_q) ? wb_dat_i : '0;
                    state_nxt   = ST_RESP;
                end else if (cnt_q != {TMO_W{1'b1}}) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            sel_q       <= 4'h0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_nxt;
            cyc_q       <= cyc_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            cnt_q       <= cnt_d;
        end
    end

    // cyc and stb come from one flop so they can never disagree.
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;
    assign cmd_ready_o = (state_q == ST_IDLE);

endmodule

// File: tb/tb_ptc_wb_master.sv
// Bench for ptc_wb_master: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ptc_wb_master;

    localparam int DW    = 32;
    localparam int TMO   = 64;
    localparam int TMO_W = 8;

    logic          wb_clk_i = 1'b0;
    logic          rst_n    = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [31:0]   cmd_adr_i = '0;
    logic [DW-1:0] cmd_dat_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;
    logic          rsp_tmo_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [31:0]   wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;

    ptc_wb_master #(.DW(DW), .TMO_CYCLES(TMO), .TMO_W(TMO_W)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Slave: 0 = ack after slv_wait waits, 1 = never answers, 2 = ack+err together, 3 = random
    int          slv_mode = 0;
    int          slv_wait = 0;
    logic [31:0] slv_dat  = '0;
    bit          in_cyc   = 1'b0;
    int          wcnt     = 0;
    int          rn       = 0;
    int          rk       = 0;

    always begin
        @(posedge wb_clk_i);
        #1;
        if (wb_cyc_o) begin
            if (!in_cyc) begin
                in_cyc = 1'b1;
                wcnt   = 0;
                rn     = $urandom_range(0, 4);
                rk     = $urandom_range(0, 15);
            end
            case (slv_mode)
                0: begin wb_ack_i = (wcnt == slv_wait); wb_err_i = 1'b0; end
                1: begin wb_ack_i = 1'b0; wb_err_i = 1'b0; end
                2: begin wb_ack_i = (wcnt == slv_wait); wb_err_i = (wcnt == slv_wait); end
                default: begin
                    // rk 0: never answer; 1,2: error; 3: ack+err; otherwise ack
                    wb_ack_i = (wcnt == rn) && rk != 0 && rk != 1 && rk != 2;
                    wb_err_i = (wcnt == rn) && (rk == 1 || rk == 2 || rk == 3);
                end
            endcase
            wcnt++;
        end else begin
            in_cyc   = 1'b0;
            wb_ack_i = (slv_mode == 3) && ($urandom_range(0, 3) == 0);
            wb_err_i = (slv_mode == 3) && ($urandom_range(0, 3) == 0);
        end
        wb_dat_i = (slv_mode == 3) ? $urandom : slv_dat;
    end

    // Transaction-level model: a pending bus transfer, a pending response, and a wait count.
    bit          m_bus = 1'b0, m_resp = 1'b0, m_we = 1'b0, m_err = 1'b0, m_tmo = 1'b0;
    logic [31:0] m_adr = '0, m_dat = '0, m_rdat = '0;
    int          m_waits = 0;

    always @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_bus = 1'b0; m_resp = 1'b0; m_waits = 0;
        end else if (m_resp) begin
            if (rsp_ready_i) m_resp = 1'b0;
        end else if (m_bus) begin
            if (wb_err_i || wb_ack_i || (TMO != 0 && m_waits == TMO - 1)) begin
                m_bus  = 1'b0;
                m_resp = 1'b1;
                m_err  = wb_err_i || !wb_ack_i;
                m_tmo  = !wb_err_i && !wb_ack_i;
                m_rdat = (!wb_err_i && wb_ack_i && !m_we) ? wb_dat_i : 32'h0;
            end else begin
                m_waits++;
            end
        end else if (cmd_valid_i) begin
            m_bus   = 1'b1;
            m_we    = cmd_we_i;
            m_adr   = cmd_adr_i & 32'hFFFF_FFFC;
            m_dat   = cmd_dat_i;
            m_waits = 0;
        end
    end

    always @(negedge wb_clk_i) begin
        if (rst_n) begin
            check("ctl", 128'({wb_cyc_o, wb_stb_o, wb_sel_o, cmd_ready_o, rsp_valid_o}),
                  128'({m_bus, m_bus, (m_bus ? 4'hF : 4'h0), (!m_bus && !m_resp), m_resp}));
            if (m_bus)
                check("bus_fields", 128'({wb_we_o, wb_adr_o, wb_dat_o}), 128'({m_we, m_adr, m_dat}));
            if (m_resp)
                check("rsp_fields", 128'({rsp_dat_o, rsp_err_o, rsp_tmo_o}), 128'({m_rdat, m_err, m_tmo}));
        end
    end

    task automatic junk_cmd(input bit valid_rand);
        cmd_valid_i = valid_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_we_i    = 1'($urandom_range(0, 1));
        cmd_adr_i   = $urandom;
        cmd_dat_i   = $urandom;
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        int k;
        k = 0;
        while (!cmd_ready_o && k < 300) begin
            @(negedge wb_clk_i);
            k++;
        end
        if (!cmd_ready_o) check("send_ready_timeout", 128'(cmd_ready_o), 128'(1));
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        @(negedge wb_clk_i);
        junk_cmd(1'b0);
    endtask

    task automatic get_rsp(input int rdly, input bit junk, output logic [31:0] rd,
                           output logic re, output logic rt, output int ncyc, output int lat);
        lat  = 1;
        ncyc = 0;
        for (int k = 0; k < 300 && !rsp_valid_o; k++) begin
            if (wb_cyc_o) ncyc++;
            if (junk) junk_cmd(1'b1);
            @(negedge wb_clk_i);
            lat++;
        end
        if (!rsp_valid_o) check("rsp_timeout", 128'(rsp_valid_o), 128'(1));
        rd = rsp_dat_o;
        re = rsp_err_o;
        rt = rsp_tmo_o;
        for (int k = 0; k < rdly; k++) begin
            if (junk) junk_cmd(1'b1);
            @(negedge wb_clk_i);
        end
        junk_cmd(1'b0);
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic        re, rt;
    int          nc, lat;

    initial begin
        #1 rst_n = 1'b0;
        #3;
        check("reset_outputs",
              128'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
                    rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o, cmd_ready_o}), 128'(1));
        #8 rst_n = 1'b1;
        @(negedge wb_clk_i);

        // Write with two wait states
        slv_mode = 0; slv_wait = 2;
        send(1'b1, 32'h0000_0004, 32'h0000_00C8);
        check("wr_bus", 128'({wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}), 128'({1'b1, 4'hF, 32'h4, 32'hC8}));
        get_rsp(0, 1'b0, rd, re, rt, nc, lat);
        check("wr_cyc_len", 128'(nc), 128'(3));
        check("wr_rsp", 128'({rd, re, rt}), 128'({32'h0, 1'b0, 1'b0}));

        // Zero-wait read
        slv_wait = 0; slv_dat = 32'h0000_0011;
        send(1'b0, 32'h0000_000C, 32'hDEAD_BEEF);
        check("rd_bus", 128'({wb_we_o, wb_adr_o}), 128'({1'b0, 32'hC}));
        get_rsp(0, 1'b0, rd, re, rt, nc, lat);
        check("rd_latency", 128'(lat), 128'(2));
        check("rd_rsp", 128'({rd, re, rt}), 128'({32'h11, 1'b0, 1'b0}));

        // Slave never answers: timeout
        slv_mode = 1;
        send(1'b0, 32'h0000_0010, 32'h0);
        get_rsp(1, 1'b0, rd, re, rt, nc, lat);
        check("tmo_cyc_len", 128'(nc), 128'(64));
        check("tmo_rsp", 128'({rd, re, rt}), 128'({32'h0, 1'b1, 1'b1}));

        // ack and err together; unaligned address
        slv_mode = 2; slv_wait = 1;
        send(1'b1, 32'h0000_0007, 32'h0000_00A5);
        check("unaligned_adr", 128'(wb_adr_o), 128'(32'h4));
        get_rsp(0, 1'b0, rd, re, rt, nc, lat);
        check("ackerr_rsp", 128'({rd, re, rt}), 128'({32'h0, 1'b1, 1'b0}));

        // Response backpressure, then back-to-back command
        slv_mode = 0; slv_wait = 0; slv_dat = 32'h0000_005A;
        send(1'b0, 32'h0000_0020, 32'h0);
        for (int k = 0; k < 10 && !rsp_valid_o; k++) @(negedge wb_clk_i);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", 128'({cmd_ready_o, rsp_valid_o, rsp_dat_o}), 128'({1'b0, 1'b1, 32'h5A}));
            @(negedge wb_clk_i);
        end
        rsp_ready_i = 1'b1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h24; cmd_dat_i = 32'h77;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        check("bp_after_hs", 128'({cmd_ready_o, wb_cyc_o, rsp_valid_o}), 128'({1'b1, 1'b0, 1'b0}));
        @(negedge wb_clk_i);
        check("bp_next_accept", 128'({wb_cyc_o, cmd_ready_o, wb_adr_o}), 128'({1'b1, 1'b0, 32'h24}));
        junk_cmd(1'b0);
        get_rsp(0, 1'b0, rd, re, rt, nc, lat);
        check("bp_next_rsp", 128'({rd, re, rt}), 128'({32'h0, 1'b0, 1'b0}));

        // Reset pulse in the middle of a bus cycle
        slv_mode = 1;
        send(1'b1, 32'h0000_0030, 32'h1);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_bus", 128'({wb_cyc_o, wb_stb_o, wb_sel_o, rsp_valid_o, cmd_ready_o}),
                 128'({1'b0, 1'b0, 4'h0, 1'b0, 1'b1}));
        #1 rst_n = 1'b1;
        @(negedge wb_clk_i);
        slv_mode = 0; slv_wait = 1; slv_dat = 32'h0000_0099;
        send(1'b0, 32'h0000_0034, 32'h0);
        get_rsp(0, 1'b0, rd, re, rt, nc, lat);
        check("post_rst_cyc_len", 128'(nc), 128'(2));
        check("post_rst_rsp", 128'({rd, re, rt}), 128'({32'h99, 1'b0, 1'b0}));

        // Randomized traffic with bus noise and stray commands
        slv_mode = 3;
        for (int t = 0; t < 150; t++) begin
            send(1'($urandom_range(0, 1)), $urandom, $urandom);
            get_rsp($urandom_range(0, 3), 1'b1, rd, re, rt, nc, lat);
        end
        slv_mode = 1;
        @(negedge wb_clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
